// File: rtl/vc_input_buffer.sv
// Virtual-channel input buffer: flit FIFO, head-flit VC allocation FSM and downstream credit counter.
// Define VC_INPUT_BUFFER_ERROR_EN to build the sticky protocol-error flag driven on error_o.
module vc_input_buffer #(
    parameter int BUFFER_SIZE = 8,
    parameter int FLIT_WIDTH  = 32,
    parameter int VC_NUM      = 2,
    parameter int CREDITS     = 8,
    localparam int VC_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [FLIT_WIDTH-1:0] flit_i,
    input  logic [1:0]            flit_type_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  vc_request_o,
    input  logic                  vc_valid_i,
    input  logic [VC_W-1:0]       vc_id_i,
    output logic                  request_o,
    input  logic                  grant_i,
    output logic [FLIT_WIDTH-1:0] flit_o,
    output logic [1:0]            flit_type_o,
    output logic [VC_W-1:0]       out_vc_o,
    input  logic                  credit_i,
    output logic                  error_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
    localparam int CR_W  = $clog2(CREDITS + 1);

    localparam logic [1:0] HEAD     = 2'b00;
    localparam logic [1:0] BODY     = 2'b01;
    localparam logic [1:0] TAIL     = 2'b10;
    localparam logic [1:0] HEADTAIL = 2'b11;

    typedef enum logic [1:0] {IDLE, VA, ACTIVE} state_t;

    logic [FLIT_WIDTH-1:0] mem_data [BUFFER_SIZE];
    logic [1:0]            mem_type [BUFFER_SIZE];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CR_W-1:0]       credits;
    logic [VC_W-1:0]       out_vc;
    state_t                state, state_next;

    logic push, pop, pop_grant, discard;
    logic head_is_start, head_is_end, credit_overflow;

    assign full_o      = (count == CNT_W'(BUFFER_SIZE));
    assign empty_o     = (count == '0);
    assign flit_o      = mem_data[rd_ptr];
    assign flit_type_o = mem_type[rd_ptr];
    assign out_vc_o    = out_vc;

    assign head_is_start = (flit_type_o == HEAD) || (flit_type_o == HEADTAIL);
    assign head_is_end   = (flit_type_o == TAIL) || (flit_type_o == HEADTAIL);

    // full_o is registered, so a push arriving while full is lost even if the same cycle pops.
    assign push      = valid_i && !full_o;
    assign pop_grant = request_o && grant_i;
    assign pop       = pop_grant || discard;

    assign credit_overflow = credit_i && !pop_grant && (credits == CR_W'(CREDITS));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_next   = state;
        vc_request_o = 1'b0;
        request_o    = 1'b0;
        discard      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_o) begin
                    if (head_is_start) state_next = VA;
                    else               discard    = 1'b1;
                end
            end
            VA: begin
                vc_request_o = 1'b1;
                if (vc_valid_i) state_next = ACTIVE;
            end
            ACTIVE: begin
                request_o = !empty_o && (credits != '0);
                if (request_o && grant_i && head_is_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            out_vc <= '0;
        end else begin
            state <= state_next;
            if (state == VA && vc_valid_i) out_vc <= vc_id_i;
        end
    end

    // NOTE: the flit storage is deliberately not reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= flit_i;
            mem_type[wr_ptr] <= flit_type_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Only flits actually sent downstream consume a credit; discarded flits do not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits <= CR_W'(CREDITS);
        end else if (credit_i && !pop_grant && !credit_overflow) begin
            credits <= credits + 1'b1;
        end else if (pop_grant && !credit_i) begin
            credits <= credits - 1'b1;
        end
    end

`ifdef VC_INPUT_BUFFER_ERROR_EN
    logic error_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error_q <= 1'b0;
        end else if ((valid_i && full_o) || discard || credit_overflow || (grant_i && !request_o)) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// Self-checking bench for vc_input_buffer: directed packet scenarios plus randomized traffic
// compared every cycle against a queue-based reference model of the buffer.
module tb_vc_input_buffer;

    localparam int BS  = 8;
    localparam int FW  = 32;
    localparam int VCN = 2;
    localparam int CR  = 8;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [FW-1:0] flit_i;
    logic [1:0]    flit_type_i;
    logic          full_o, empty_o, vc_request_o, vc_valid_i;
    logic [0:0]    vc_id_i;
    logic          request_o, grant_i;
    logic [FW-1:0] flit_o;
    logic [1:0]    flit_type_o;
    logic [0:0]    out_vc_o;
    logic          credit_i, error_o;

    vc_input_buffer #(
        .BUFFER_SIZE(BS), .FLIT_WIDTH(FW), .VC_NUM(VCN), .CREDITS(CR)
    ) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .flit_i(flit_i), .flit_type_i(flit_type_i),
        .full_o(full_o), .empty_o(empty_o),
        .vc_request_o(vc_request_o), .vc_valid_i(vc_valid_i), .vc_id_i(vc_id_i),
        .request_o(request_o), .grant_i(grant_i),
        .flit_o(flit_o), .flit_type_o(flit_type_o), .out_vc_o(out_vc_o),
        .credit_i(credit_i), .error_o(error_o)
    );

    always #5 clk = ~clk;

    // Reference model: packet-level view of the buffer.
    typedef struct {
        logic [FW-1:0] d;
        logic [1:0]    t;
    } flit_t;
    typedef enum int {M_IDLE, M_VA, M_ACTIVE} mode_t;

    flit_t q[$];
    mode_t mode;
    int    cr;
    int    vc;
    bit    err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_req();
        return (mode == M_ACTIVE) && (q.size() > 0) && (cr > 0);
    endfunction

    task automatic model_reset();
        q.delete();
        mode = M_IDLE;
        cr   = CR;
        vc   = 0;
        err  = 1'b0;
    endtask

    task automatic check_outputs(input string where);
        bit exp_err;
`ifdef VC_INPUT_BUFFER_ERROR_EN
        exp_err = err;
`else
        exp_err = 1'b0;
`endif
        check({where, ".empty"}, 64'(empty_o), 64'(q.size() == 0));
        check({where, ".full"}, 64'(full_o), 64'(q.size() == BS));
        check({where, ".vc_req"}, 64'(vc_request_o), 64'(mode == M_VA));
        check({where, ".req"}, 64'(request_o), 64'(model_req()));
        check({where, ".out_vc"}, 64'(out_vc_o), 64'(vc));
        check({where, ".error"}, 64'(error_o), 64'(exp_err));
        if (q.size() > 0) begin
            check({where, ".flit"}, 64'(flit_o), 64'(q[0].d));
            check({where, ".type"}, 64'(flit_type_o), 64'(q[0].t));
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit    full, req, pg, disc, psh;
        flit_t e;
        full = (q.size() == BS);
        req  = model_req();
        pg   = req && grant_i;
        disc = (mode == M_IDLE) && (q.size() > 0) && (q[0].t == T_BODY || q[0].t == T_TAIL);
        psh  = valid_i && !full;
        if ((valid_i && full) || disc || (grant_i && !req) || (credit_i && !pg && cr == CR))
            err = 1'b1;
        case (mode)
            M_IDLE:   if (q.size() > 0 && !disc) mode = M_VA;
            M_VA:     if (vc_valid_i) begin mode = M_ACTIVE; vc = int'(vc_id_i); end
            M_ACTIVE: if (pg && (q[0].t == T_TAIL || q[0].t == T_HT)) mode = M_IDLE;
            default:  mode = M_IDLE;
        endcase
        if (pg || disc) void'(q.pop_front());
        if (psh) begin
            e.d = flit_i;
            e.t = flit_type_i;
            q.push_back(e);
        end
        cr = cr + int'(credit_i) - int'(pg);
        if (cr > CR) cr = CR;
    endtask

    task automatic drive_idle();
        valid_i     = 1'b0;
        flit_i      = '0;
        flit_type_i = T_HEAD;
        vc_valid_i  = 1'b0;
        vc_id_i     = 1'b0;
        grant_i     = 1'b0;
        credit_i    = 1'b0;
    endtask

    task automatic cycle(input bit v, input logic [1:0] t, input bit vcv, input logic [0:0] vid,
                         input bit g, input bit ci, input string where);
        @(negedge clk);
        valid_i     = v;
        flit_i      = $urandom;
        flit_type_i = t;
        vc_valid_i  = vcv;
        vc_id_i     = vid;
        grant_i     = g;
        credit_i    = ci;
        #1 check_outputs(where);
        model_step();
        @(posedge clk);
    endtask

    // Reset is asserted mid-cycle, away from any edge, so the outputs must react without a clock.
    task automatic do_reset(input string where);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check({where, ".rst_empty"}, 64'(empty_o), 64'(1));
        check({where, ".rst_full"}, 64'(full_o), 64'(0));
        check({where, ".rst_req"}, 64'(request_o), 64'(0));
        check({where, ".rst_vcreq"}, 64'(vc_request_o), 64'(0));
        check({where, ".rst_err"}, 64'(error_o), 64'(0));
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        model_step();
    endtask

    logic       r_v, r_vcv, r_g, r_ci;
    logic [1:0] r_t;
    logic [0:0] r_vid;
    bit         in_pkt;

    initial begin
        rst = 1'b0;
        drive_idle();
        model_reset();
        #1 check_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // One three-flit packet, VC 1 granted in the first VA cycle, every request granted.
        cycle(1, T_HEAD, 0, 0, 0, 0, "pkt");
        cycle(1, T_BODY, 0, 0, 0, 0, "pkt");
        cycle(1, T_TAIL, 1, 1, 0, 0, "pkt");
        repeat (5) cycle(0, T_HEAD, 0, 0, model_req(), 0, "pkt_drain");

        // Fill past capacity with no grants, then pop and push together while full.
        do_reset("fill");
        cycle(1, T_HEAD, 0, 0, 0, 0, "fill");
        repeat (8) cycle(1, T_BODY, 0, 0, 0, 0, "fill");
        cycle(1, T_BODY, 1, 0, 0, 0, "fill_va");
        cycle(1, T_BODY, 0, 0, model_req(), 0, "full_pop");
        repeat (4) cycle(0, T_HEAD, 0, 0, model_req(), 0, "full_drain");

        // Stray BODY into an idle, empty buffer.
        do_reset("stray");
        cycle(1, T_BODY, 0, 0, 0, 0, "stray");
        repeat (3) cycle(0, T_HEAD, 0, 0, 0, 0, "stray_after");

        // Credit exhaustion: requests stop once credits run out, one credit releases one pop.
        do_reset("credit");
        cycle(1, T_HEAD, 0, 0, 0, 0, "credit");
        repeat (13) cycle(1, T_BODY, 1, 1, model_req(), 0, "credit_run");
        cycle(0, T_HEAD, 0, 0, 0, 1, "credit_ret");
        repeat (3) cycle(0, T_HEAD, 0, 0, model_req(), 0, "credit_one");

        // Asynchronous reset mid-packet with three flits buffered.
        do_reset("mid");
        cycle(1, T_HEAD, 0, 0, 0, 0, "mid");
        cycle(1, T_BODY, 0, 0, 0, 0, "mid");
        cycle(1, T_BODY, 1, 0, 0, 0, "mid");
        cycle(0, T_HEAD, 0, 0, 0, 0, "mid_active");
        do_reset("mid_rst");
        cycle(0, T_HEAD, 0, 0, 0, 0, "mid_after");

        // Randomized traffic: mostly well-formed packets, occasional malformed types and resets.
        in_pkt = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r_v = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 5)  r_t = 2'($urandom);
            else if (!in_pkt)               r_t = ($urandom_range(0, 2) == 0) ? T_HT : T_HEAD;
            else                            r_t = ($urandom_range(0, 2) == 0) ? T_TAIL : T_BODY;
            if (r_v && q.size() < BS) in_pkt = (r_t == T_HEAD || r_t == T_BODY);
            r_g   = model_req() ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) == 0);
            r_ci  = (cr < CR) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            r_vcv = 1'($urandom_range(0, 1));
            r_vid = 1'($urandom_range(0, 1));
            cycle(r_v, r_t, r_vcv, r_vid, r_g, r_ci, "rand");
            if ($urandom_range(0, 599) == 0) begin
                do_reset("rand_rst");
                in_pkt = 1'b0;
            end
        end
        cycle(0, T_HEAD, 0, 0, 0, 0, "final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
